// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: 32-bit signed divider using a multicycle restoring algorithm.
//
// Behaviour:
//   - A start produces MIPS-style results: LO is the quotient, truncated
//     toward zero. HI is the remainder and takes the sign of the dividend.
//   - A zero divisor is reported on div_zero together with a one-cycle
//     div_done pulse. No iteration runs in that case.
//   - Results appear 33 clocks after the accepted start edge.
//
// Optional build macro DIV_UNSIGNED_EN:
//   - Adds the div_signed input.
//   - div_signed=0 selects an unsigned divide (divu) with the same latency.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   div_start   in   start request, sampled only while idle
//   a_in        in   dividend (A register)
//   b_in        in   divisor (B register)
//   div_signed  in   1 = signed divide, 0 = unsigned (only with DIV_UNSIGNED_EN)
//   lo_out      out  quotient
//   hi_out      out  remainder
//   div_busy    out  division in progress
//   div_done    out  one-cycle pulse when results or the zero flag are valid
//   div_zero    out  divisor was zero on the last accepted start
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef DIV_UNSIGNED_EN
    input  logic             div_signed,
`endif
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(WIDTH);

    // Two's complement negate; -(2^(WIDTH-1)) wraps to itself, which is the
    // correct unsigned magnitude and also the correct overflow quotient.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q,   dvs_d;   // divisor magnitude
    logic [WIDTH-1:0] rem_q,   rem_d;   // partial remainder
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic             done_q,  done_d;
    logic             zero_q,  zero_d;

    // Trial subtraction: bring in the next dividend bit, then subtract.
    // A clear MSB of diff means the divisor fit.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sign_q_q <= sign_q_d;
            sign_r_q <= sign_r_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        sign_q_d = sign_q_q;
        sign_r_d = sign_r_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        done_d   = 1'b0;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    if (b_in == '0) begin
                        // Reported immediately; results are left untouched.
                        zero_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
`ifdef DIV_UNSIGNED_EN
                        dvd_d    = div_signed ? magnitude(a_in) : a_in;
                        dvs_d    = div_signed ? magnitude(b_in) : b_in;
                        sign_q_d = div_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        sign_r_d = div_signed & a_in[WIDTH-1];
`else
                        dvd_d    = magnitude(a_in);
                        dvs_d    = magnitude(b_in);
                        sign_q_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        sign_r_d = a_in[WIDTH-1];
`endif
                        rem_d   = '0;
                        cnt_d   = CNT_INI;
                        zero_d  = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = sign_q_q ? negate(dvd_q) : dvd_q;
                hi_d    = sign_r_q ? negate(rem_q) : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign div_busy = (state_q != IDLE);
    assign div_done = done_q;
    assign div_zero = zero_q;

endmodule
